// File: rtl/register_file_sb.sv
// 2-read/1-write register file with a clear sweep sequencer and per-register pending scoreboard.
// Optional write-first read bypass enabled by defining REGFILE_BYPASS_EN.
module register_file_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] rg_A1,
    input  logic [ADDR_WIDTH-1:0] rg_A2,
    output logic [DATA_WIDTH-1:0] rg_RD1,
    output logic [DATA_WIDTH-1:0] rg_RD2,
    output logic                  rg_PEND1,
    output logic                  rg_PEND2,
    input  logic [ADDR_WIDTH-1:0] rg_A3,
    input  logic [DATA_WIDTH-1:0] rg_WD3,
    input  logic                  rg_WE3,
    input  logic [ADDR_WIDTH-1:0] rg_AR,
    input  logic                  rg_RES,
    input  logic                  rg_CLR,
    output logic                  rg_READY,
    output logic                  rg_WERR
);
    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam bit ZR    = (ZERO_REG != 0);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t                  state, next_state;
    logic [ADDR_WIDTH-1:0]   counter;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DEPTH-1:0]        pend;
    logic                    wr_ok, res_ok;

    assign wr_ok  = (state == RUN) && rg_WE3 && !(ZR && rg_A3 == '0);
    assign res_ok = (state == RUN) && rg_RES && !(ZR && rg_AR == '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= CLEAR;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            CLEAR: if (!rg_CLR && counter == '1) next_state = RUN;
            RUN:   if (rg_CLR) next_state = CLEAR;
            default: next_state = CLEAR;
        endcase
    end

    // Counter idles at 0 in RUN so a CLR entry always starts the sweep at register 0.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            counter <= '0;
        else if (state == CLEAR && !rg_CLR && counter != '1)
            counter <= counter + ADDR_WIDTH'(1);
        else
            counter <= '0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rg_READY <= 1'b0;
            rg_WERR  <= 1'b0;
        end else begin
            rg_READY <= (next_state == RUN);
            rg_WERR  <= (state != RUN) && (rg_WE3 || rg_RES);
        end
    end

    // Reserve is applied after the write clear so a same-edge reserve wins.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            pend <= '0;
        else if (state != RUN || rg_CLR)
            pend <= '0;
        else begin
            if (wr_ok)  pend[rg_A3] <= 1'b0;
            if (res_ok) pend[rg_AR] <= 1'b1;
        end
    end

    // No reset on the array so it can map onto RAM; the sweep initialises it.
    always_ff @(posedge clock) begin
        if (state == CLEAR)
            mem[counter] <= '0;
        else if (wr_ok)
            mem[rg_A3] <= rg_WD3;
    end

    always_comb begin
        rg_RD1   = '0;
        rg_PEND1 = 1'b0;
        if (state == RUN && !(ZR && rg_A1 == '0)) begin
            rg_RD1   = mem[rg_A1];
            rg_PEND1 = pend[rg_A1];
`ifdef REGFILE_BYPASS_EN
            if (wr_ok && rg_A3 == rg_A1) begin
                rg_RD1   = rg_WD3;
                rg_PEND1 = rg_RES && (rg_AR == rg_A1);
            end
`endif
        end
    end

    always_comb begin
        rg_RD2   = '0;
        rg_PEND2 = 1'b0;
        if (state == RUN && !(ZR && rg_A2 == '0)) begin
            rg_RD2   = mem[rg_A2];
            rg_PEND2 = pend[rg_A2];
`ifdef REGFILE_BYPASS_EN
            if (wr_ok && rg_A3 == rg_A2) begin
                rg_RD2   = rg_WD3;
                rg_PEND2 = rg_RES && (rg_AR == rg_A2);
            end
`endif
        end
    end
endmodule

// File: tb/tb_register_file_sb.sv
// Self-checking bench for register_file_sb: abstract behavioural model checked every
// negedge, plus directed vectors with hand-computed literal expectations.
module tb_register_file_sb;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int DEPTH = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] rg_A1 = '0, rg_A2 = '0, rg_A3 = '0, rg_AR = '0;
    logic [DW-1:0] rg_WD3 = '0;
    logic          rg_WE3 = 1'b0, rg_RES = 1'b0, rg_CLR = 1'b0;
    logic [DW-1:0] rg_RD1, rg_RD2;
    logic          rg_PEND1, rg_PEND2, rg_READY, rg_WERR;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    register_file_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1)) dut (
        .clock(clock), .reset(reset),
        .rg_A1(rg_A1), .rg_A2(rg_A2), .rg_RD1(rg_RD1), .rg_RD2(rg_RD2),
        .rg_PEND1(rg_PEND1), .rg_PEND2(rg_PEND2),
        .rg_A3(rg_A3), .rg_WD3(rg_WD3), .rg_WE3(rg_WE3),
        .rg_AR(rg_AR), .rg_RES(rg_RES), .rg_CLR(rg_CLR),
        .rg_READY(rg_READY), .rg_WERR(rg_WERR)
    );

    always #5 clock = ~clock;

    // Behavioural model: ready flag plus a countdown of sweep edges still owed.
    bit          m_ready;
    int          m_left;
    bit          m_werr;
    logic [DW-1:0] m_mem [DEPTH];
    bit          m_pend [DEPTH];

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_ready = 0; m_left = DEPTH; m_werr = 0;
            for (int i = 0; i < DEPTH; i++) m_pend[i] = 0;
        end else begin
            m_werr = !m_ready && (rg_WE3 || rg_RES);
            if (!m_ready) begin
                if (rg_CLR) m_left = DEPTH;
                else begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        m_ready = 1;
                        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
                    end
                end
            end else begin
                if (rg_WE3 && rg_A3 != 0) begin m_mem[rg_A3] = rg_WD3; m_pend[rg_A3] = 0; end
                if (rg_RES && rg_AR != 0) m_pend[rg_AR] = 1;
                if (rg_CLR) begin
                    m_ready = 0; m_left = DEPTH;
                    for (int i = 0; i < DEPTH; i++) m_pend[i] = 0;
                end
            end
        end
    end

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
        if (!m_ready || a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (rg_WE3 && rg_A3 == a) return rg_WD3;
`endif
        return m_mem[a];
    endfunction

    function automatic logic exp_pend(input logic [AW-1:0] a);
        if (!m_ready || a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (rg_WE3 && rg_A3 == a) return rg_RES && (rg_AR == a);
`endif
        return m_pend[a];
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            chk("model_ready", {31'd0, rg_READY}, {31'd0, m_ready});
            chk("model_werr",  {31'd0, rg_WERR},  {31'd0, m_werr});
            chk("model_rd1",   rg_RD1, exp_rd(rg_A1));
            chk("model_rd2",   rg_RD2, exp_rd(rg_A2));
            chk("model_pend1", {31'd0, rg_PEND1}, {31'd0, exp_pend(rg_A1)});
            chk("model_pend2", {31'd0, rg_PEND2}, {31'd0, exp_pend(rg_A2)});
        end
    end

    task automatic tick();
        @(posedge clock); #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic read_all(input bit filled);
        for (int i = 0; i < DEPTH / 2; i++) begin
            rg_A1 = AW'(2*i); rg_A2 = AW'(2*i + 1); #1;
            chk("pair_rd1", rg_RD1, (filled && i != 0) ? DW'(1000 + 2*i) : '0);
            chk("pair_rd2", rg_RD2, filled ? DW'(1000 + 2*i + 1) : '0);
            chk("pair_pend", {30'd0, rg_PEND1, rg_PEND2}, '0);
        end
    endtask

    task automatic fill();
        rg_WE3 = 1;
        for (int i = 0; i < DEPTH; i++) begin
            rg_A3 = AW'(i); rg_WD3 = DW'(1000 + i); tick();
        end
        rg_WE3 = 0;
    endtask

    initial begin
        #2 reset = 0;
        #1 chk_en = 1;
        chk("reset_ready", {31'd0, rg_READY}, '0);
        chk("reset_werr",  {31'd0, rg_WERR}, '0);
        #14 reset = 1;                       // low for 15 ns
        ticks(31);
        chk("ready_edge31", {31'd0, rg_READY}, '0);
        tick();
        chk("ready_edge32", {31'd0, rg_READY}, 32'd1);
        read_all(0);

        fill();
        read_all(1);

        // reserve, then CLR: pending must clear, READY drops the next cycle
        rg_RES = 1; rg_AR = 3; tick(); rg_RES = 0;
        rg_A1 = 3; #1;
        chk("pend_before_clr", {31'd0, rg_PEND1}, 32'd1);
        rg_CLR = 1; tick(); rg_CLR = 0;
        chk("clr_ready_drop", {31'd0, rg_READY}, '0);
        chk("clr_pend", {31'd0, rg_PEND1}, '0);
        rg_WE3 = 1; rg_A3 = 5; rg_WD3 = 77; tick(); rg_WE3 = 0;
        chk("werr_pulse", {31'd0, rg_WERR}, 32'd1);
        tick();
        chk("werr_single", {31'd0, rg_WERR}, '0);
        ticks(29);
        chk("clr_edge31", {31'd0, rg_READY}, '0);
        tick();
        chk("clr_edge32", {31'd0, rg_READY}, 32'd1);
        rg_A1 = 5; #1;
        chk("reg5_zero", rg_RD1, '0);
        read_all(0);

        // refill, CLR, then reset mid-sweep restarts the 32-edge count
        fill();
        rg_CLR = 1; tick(); rg_CLR = 0;
        ticks(10);
        #1 reset = 0;
        #2 reset = 1;
        ticks(31);
        chk("rst_mid_edge31", {31'd0, rg_READY}, '0);
        tick();
        chk("rst_mid_edge32", {31'd0, rg_READY}, 32'd1);
        read_all(0);

        // scoreboard: reserve, write clears, same-edge reserve wins
        rg_RES = 1; rg_AR = 7; rg_A1 = 7; rg_A2 = 8; tick(); rg_RES = 0;
        chk("res7_pend1", {31'd0, rg_PEND1}, 32'd1);
        chk("res7_pend2_other", {31'd0, rg_PEND2}, '0);
        rg_WE3 = 1; rg_A3 = 7; rg_WD3 = 42; tick(); rg_WE3 = 0;
        chk("wr7_pend1", {31'd0, rg_PEND1}, '0);
        chk("wr7_rd1", rg_RD1, 32'd42);
        rg_WE3 = 1; rg_RES = 1; rg_WD3 = 55; tick(); rg_WE3 = 0; rg_RES = 0;
        chk("reswr7_rd1", rg_RD1, 32'd55);
        chk("reswr7_pend1", {31'd0, rg_PEND1}, 32'd1);

        // zero register ignores writes and reserves
        rg_WE3 = 1; rg_A3 = 0; rg_WD3 = 99; rg_RES = 1; rg_AR = 0; tick();
        rg_WE3 = 0; rg_RES = 0; rg_A1 = 0; #1;
        chk("zero_rd", rg_RD1, '0);
        chk("zero_pend", {31'd0, rg_PEND1}, '0);

        // read of a register being written in the same cycle
        rg_WE3 = 1; rg_A3 = 9; rg_WD3 = 100; tick();
        rg_WD3 = 123; rg_A1 = 9; #1;
`ifdef REGFILE_BYPASS_EN
        chk("same_cycle_rd1", rg_RD1, 32'd123);
`else
        chk("same_cycle_rd1", rg_RD1, 32'd100);
`endif
        tick(); rg_WE3 = 0;
        chk("after_edge_rd1", rg_RD1, 32'd123);

        // reserve while not ready also flags WERR
        rg_CLR = 1; tick(); rg_CLR = 0;
        rg_RES = 1; rg_AR = 4; tick(); rg_RES = 0;
        chk("werr_res", {31'd0, rg_WERR}, 32'd1);
        ticks(31);
        chk("final_ready", {31'd0, rg_READY}, 32'd1);
        rg_A1 = 4; #1;
        chk("final_pend4", {31'd0, rg_PEND1}, '0);

        @(negedge clock); #1;
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
